hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Pipeline-control counterpart to the forwarding logic in the 5-stage RV32I core.
- Detects hazards that bypassing cannot resolve: load-use, taken branch/jump in EX, and data-memory wait states.
- Drives PC/IF-ID hold, ID-EX bubble, flushes and a global freeze.
- Holds a small FSM for multi-cycle memory waits with timeout, plus saturating stall performance counters.

Parameters:
- TIMEOUT, 16, maximum consecutive MEM_WAIT cycles before ERROR is entered.
- CNT_W, 16, width of each performance counter.

Ports:
- CLK  input  1  core clock, rising edge
- RST  input  1  synchronous, active-high reset
- ARS1_ID  input  5  rs1 address of the instruction in ID
- ARS2_ID  input  5  rs2 address of the instruction in ID
- USES_RS1_ID  input  1  ID instruction reads rs1
- USES_RS2_ID  input  1  ID instruction reads rs2
- ARD_ID_EX  input  5  rd of the instruction in EX
- MEMREAD_ID_EX  input  1  instruction in EX is a load
- BRANCH_TAKEN_EX  input  1  branch/jump resolved taken in EX
- DMEM_REQ  input  1  MEM stage holds a load/store this cycle
- DMEM_READY  input  1  data memory completes the access this cycle
- STALL_PC  output  1  hold PC
- STALL_IF_ID  output  1  hold the IF/ID register
- BUBBLE_ID_EX  output  1  load a NOP into ID/EX
- FLUSH_IF_ID  output  1  clear IF/ID
- FLUSH_ID_EX  output  1  clear ID/EX
- FREEZE  output  1  hold all pipeline registers and the PC
- MEM_ERR  output  1  sticky; set on memory timeout
- HZ_STATE  output  2  current FSM state (debug)
- LU_CNT  output  CNT_W  load-use stall cycles, saturating
- MW_CNT  output  CNT_W  memory-wait freeze cycles, saturating

Behaviour:
- Single clock CLK. Reset is synchronous, active-high on RST.
- While RST=1, on the next edge: state=RUN, wait counter=0, MEM_ERR=0, LU_CNT=0, MW_CNT=0.
- All control outputs are combinational from the current state and inputs. They are 0 whenever RST=1.
- Load-use condition LU:
  - MEMREAD_ID_EX && ARD_ID_EX!=0
  - and ((USES_RS1_ID && ARD_ID_EX==ARS1_ID) || (USES_RS2_ID && ARD_ID_EX==ARS2_ID)).
  - An x0 destination never stalls.
- FSM states (enum hz_state_t): RUN=0, MEM_WAIT=1, ERROR=2.
- RUN:
  - If DMEM_REQ && !DMEM_READY: FREEZE=1, all other controls 0, next=MEM_WAIT, wait counter loads 1.
  - Else if BRANCH_TAKEN_EX: FLUSH_IF_ID=1, FLUSH_ID_EX=1. LU is ignored because the dependent instruction is being flushed. No stall.
  - Else if LU: STALL_PC=1, STALL_IF_ID=1, BUBBLE_ID_EX=1. Exactly one bubble per load, since next cycle the load has moved to MEM and the condition clears.
  - DMEM_REQ && DMEM_READY in the same cycle is a zero-wait access: no freeze.
- MEM_WAIT:
  - FREEZE=1. STALL/BUBBLE/FLUSH are forced 0, because freeze dominates and held stages re-present their hazards after release.
  - If DMEM_READY: FREEZE=0 this cycle, normal RUN priority rules apply this cycle, next=RUN.
  - Else if wait counter==TIMEOUT: next=ERROR, MEM_ERR set.
  - Else the wait counter increments.
- ERROR:
  - FREEZE=1 permanently and MEM_ERR=1.
  - Left only by RST.
- Counters:
  - LU_CNT increments on cycles with BUBBLE_ID_EX=1.
  - MW_CNT increments on cycles with FREEZE=1 in state MEM_WAIT or RUN.
  - Both saturate at 2^CNT_W-1 with no wrap.
- The wait counter width is $clog2(TIMEOUT+1). It reloads on every new entry into MEM_WAIT.
- Reset mid-wait returns to RUN in one edge. Outputs are 0 in the reset cycle.

Decomposition:
- Package pipe_ctrl_pkg:
  - hz_state_t enum.
  - REG_ZERO=5'd0.
  - NOP encoding constant 32'h00000013 for the ID/EX bubble.
- Sub-module sat_counter (parameter W; ports CLK, RST, INC, Q), instantiated twice for LU_CNT and MW_CNT.

Test Plan:
- Load-use:
  - Stimulus: MEMREAD_ID_EX=1, ARD_ID_EX=5, ARS1_ID=5, USES_RS1_ID=1.
  - Required: STALL_PC=STALL_IF_ID=BUBBLE_ID_EX=1 for one cycle; LU_CNT 0→1.
  - Repeat with ARD_ID_EX=0: no stall.
- Branch over load-use:
  - Stimulus: LU condition and BRANCH_TAKEN_EX=1 together.
  - Required: FLUSH_IF_ID=FLUSH_ID_EX=1, STALL_PC=0, LU_CNT unchanged.
- Memory wait:
  - Stimulus: DMEM_REQ=1, DMEM_READY=0 for 3 cycles, then READY=1.
  - Required: FREEZE=1 for 3 cycles, HZ_STATE=1 during the wait, then 0; MW_CNT=3.
- Timeout (TIMEOUT=4):
  - Stimulus: READY held low.
  - Required: HZ_STATE=2, MEM_ERR=1 and FREEZE=1 persist until RST; after RST all outputs 0 and counters 0.
- Saturation (CNT_W=4):
  - Stimulus: 20 load-use events.
  - Required: LU_CNT=15, no wrap.
- Zero-wait access:
  - Stimulus: DMEM_REQ=1 with DMEM_READY=1.
  - Required: FREEZE=0 and state stays RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall control logic.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_t;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0, x0, 0 injected as the ID/EX bubble

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         INC,
    output logic [W-1:0] Q
);

    always_ff @(posedge CLK) begin
        if (RST)
            Q <= '0;
        else if (INC && (Q != '1))
            Q <= Q + W'(1);
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stall, taken-branch flush, data-memory
// wait freeze with timeout, and saturating stall counters.
module hazard_control_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       ARS1_ID,
    input  logic [4:0]       ARS2_ID,
    input  logic             USES_RS1_ID,
    input  logic             USES_RS2_ID,
    input  logic [4:0]       ARD_ID_EX,
    input  logic             MEMREAD_ID_EX,
    input  logic             BRANCH_TAKEN_EX,
    input  logic             DMEM_REQ,
    input  logic             DMEM_READY,
    output logic             STALL_PC,
    output logic             STALL_IF_ID,
    output logic             BUBBLE_ID_EX,
    output logic             FLUSH_IF_ID,
    output logic             FLUSH_ID_EX,
    output logic             FREEZE,
    output logic             MEM_ERR,
    output logic [1:0]       HZ_STATE,
    output logic [CNT_W-1:0] LU_CNT,
    output logic [CNT_W-1:0] MW_CNT
);

    localparam int            WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] TO = WW'(TIMEOUT);

    hz_state_t     state, state_nxt;
    logic [WW-1:0] wcnt, wcnt_nxt;
    logic          mem_err_q, err_set;
    logic          lu, run_rules;
    logic          stall_c, flush_c, freeze_c;

    assign lu = MEMREAD_ID_EX && (ARD_ID_EX != REG_ZERO) &&
                ((USES_RS1_ID && (ARD_ID_EX == ARS1_ID)) ||
                 (USES_RS2_ID && (ARD_ID_EX == ARS2_ID)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            wcnt      <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (err_set)
                mem_err_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        err_set   = 1'b0;
        run_rules = 1'b0;
        stall_c   = 1'b0;
        flush_c   = 1'b0;
        freeze_c  = 1'b0;
        case (state)
            RUN: run_rules = 1'b1;
            MEM_WAIT: begin
                if (DMEM_READY) begin
                    // Release cycle behaves like RUN so held hazards resolve now.
                    run_rules = 1'b1;
                    state_nxt = RUN;
                end else begin
                    freeze_c = 1'b1;
                    if (wcnt == TO) begin
                        state_nxt = ERROR;
                        err_set   = 1'b1;
                    end else begin
                        wcnt_nxt = wcnt + WW'(1);
                    end
                end
            end
            ERROR:   freeze_c  = 1'b1;
            default: state_nxt = RUN;
        endcase
        if (run_rules) begin
            if (DMEM_REQ && !DMEM_READY) begin
                freeze_c  = 1'b1;
                state_nxt = MEM_WAIT;
                wcnt_nxt  = WW'(1);
            end else if (BRANCH_TAKEN_EX) begin
                flush_c = 1'b1;
            end else if (lu) begin
                stall_c = 1'b1;
            end
        end
    end

    assign STALL_PC     = stall_c  && !RST;
    assign STALL_IF_ID  = stall_c  && !RST;
    assign BUBBLE_ID_EX = stall_c  && !RST;
    assign FLUSH_IF_ID  = flush_c  && !RST;
    assign FLUSH_ID_EX  = flush_c  && !RST;
    assign FREEZE       = freeze_c && !RST;
    assign MEM_ERR      = mem_err_q;
    assign HZ_STATE     = state;

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .CLK (CLK),
        .RST (RST),
        .INC (BUBBLE_ID_EX),
        .Q   (LU_CNT)
    );

    sat_counter #(.W(CNT_W)) u_mw_cnt (
        .CLK (CLK),
        .RST (RST),
        .INC (FREEZE && (state == RUN || state == MEM_WAIT)),
        .Q   (MW_CNT)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit (TIMEOUT=4, CNT_W=4).
module tb_hazard_control_unit;

    typedef struct packed {
        logic [4:0] ars1;
        logic [4:0] ars2;
        logic       u1;
        logic       u2;
        logic [4:0] ard;
        logic       mr;
        logic       br;
        logic       req;
        logic       rdy;
    } in_t;

    typedef struct packed {
        logic       spc;
        logic       sif;
        logic       bub;
        logic       fif;
        logic       fid;
        logic       frz;
        logic       merr;
        logic [1:0] st;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [4:0] ARS1_ID = '0, ARS2_ID = '0, ARD_ID_EX = '0;
    logic       USES_RS1_ID = 0, USES_RS2_ID = 0, MEMREAD_ID_EX = 0;
    logic       BRANCH_TAKEN_EX = 0, DMEM_REQ = 0, DMEM_READY = 0;
    logic       STALL_PC, STALL_IF_ID, BUBBLE_ID_EX, FLUSH_IF_ID, FLUSH_ID_EX;
    logic       FREEZE, MEM_ERR;
    logic [1:0] HZ_STATE;
    logic [3:0] LU_CNT, MW_CNT;

    int total = 0;
    int bad   = 0;
    int lu_m  = 0;
    int mw_m  = 0;
    exp_t sb_q[$];

    always #5 CLK = ~CLK;

    hazard_control_unit #(.TIMEOUT(4), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST),
        .ARS1_ID(ARS1_ID), .ARS2_ID(ARS2_ID),
        .USES_RS1_ID(USES_RS1_ID), .USES_RS2_ID(USES_RS2_ID),
        .ARD_ID_EX(ARD_ID_EX), .MEMREAD_ID_EX(MEMREAD_ID_EX),
        .BRANCH_TAKEN_EX(BRANCH_TAKEN_EX),
        .DMEM_REQ(DMEM_REQ), .DMEM_READY(DMEM_READY),
        .STALL_PC(STALL_PC), .STALL_IF_ID(STALL_IF_ID), .BUBBLE_ID_EX(BUBBLE_ID_EX),
        .FLUSH_IF_ID(FLUSH_IF_ID), .FLUSH_ID_EX(FLUSH_ID_EX),
        .FREEZE(FREEZE), .MEM_ERR(MEM_ERR), .HZ_STATE(HZ_STATE),
        .LU_CNT(LU_CNT), .MW_CNT(MW_CNT)
    );

    function automatic in_t mk(input logic [4:0] ars1, input logic [4:0] ars2,
                               input logic u1, input logic u2, input logic [4:0] ard,
                               input logic mr, input logic br, input logic req,
                               input logic rdy);
        mk = '{ars1, ars2, u1, u2, ard, mr, br, req, rdy};
    endfunction

    function automatic exp_t ex(input logic stall, input logic flush, input logic frz,
                                input logic merr, input logic [1:0] st);
        ex = '{stall, stall, stall, flush, flush, frz, merr, st};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic drive(input in_t i);
        ARS1_ID = i.ars1; ARS2_ID = i.ars2; USES_RS1_ID = i.u1; USES_RS2_ID = i.u2;
        ARD_ID_EX = i.ard; MEMREAD_ID_EX = i.mr; BRANCH_TAKEN_EX = i.br;
        DMEM_REQ = i.req; DMEM_READY = i.rdy;
    endtask

    // One cycle: drive, score combinational outputs, then score counters after the edge.
    task automatic step(input string name, input in_t i, input exp_t e);
        exp_t  got, want;
        @(negedge CLK);
        drive(i);
        sb_q.push_back(e);
        #1;
        want = sb_q.pop_front();
        got  = '{STALL_PC, STALL_IF_ID, BUBBLE_ID_EX, FLUSH_IF_ID, FLUSH_ID_EX,
                 FREEZE, MEM_ERR, HZ_STATE};
        check({name, "/ctl"}, 32'(got), 32'(want));
        @(posedge CLK);
        if (want.bub && lu_m < 15) lu_m++;
        if (want.frz && want.st != 2'd2 && mw_m < 15) mw_m++;
        #1;
        check({name, "/lu_cnt"}, 32'(LU_CNT), 32'(lu_m));
        check({name, "/mw_cnt"}, 32'(MW_CNT), 32'(mw_m));
    endtask

    task automatic do_reset(input string name);
        @(negedge CLK);
        RST = 1'b1;
        drive(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0));
        #1;
        check({name, "/rst_ctl"},
              32'({STALL_PC, STALL_IF_ID, BUBBLE_ID_EX, FLUSH_IF_ID, FLUSH_ID_EX, FREEZE}), 32'd0);
        @(posedge CLK);
        #1;
        lu_m = 0;
        mw_m = 0;
        RST  = 1'b0;
        check({name, "/rst_state"}, 32'({HZ_STATE, MEM_ERR}), 32'd0);
        check({name, "/rst_cnt"}, 32'({LU_CNT, MW_CNT}), 32'd0);
    endtask

    in_t idle, lu1, req_wait, req_rdy, lu_rdy;
    vec_t tbl[9];

    initial begin
        idle     = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
        lu1      = mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0);
        req_wait = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        req_rdy  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
        lu_rdy   = mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 1, 1);

        tbl[0] = '{idle,                                          ex(0, 0, 0, 0, 2'd0)};
        tbl[1] = '{lu1,                                           ex(1, 0, 0, 0, 2'd0)};
        tbl[2] = '{mk(5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0),        ex(0, 0, 0, 0, 2'd0)};
        tbl[3] = '{mk(5'd1, 5'd7, 0, 1, 5'd7, 1, 0, 0, 0),        ex(1, 0, 0, 0, 2'd0)};
        tbl[4] = '{mk(5'd1, 5'd7, 1, 0, 5'd7, 1, 0, 0, 0),        ex(0, 0, 0, 0, 2'd0)};
        tbl[5] = '{mk(5'd5, 5'd0, 1, 0, 5'd5, 0, 0, 0, 0),        ex(0, 0, 0, 0, 2'd0)};
        tbl[6] = '{mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0),        ex(0, 1, 0, 0, 2'd0)};
        tbl[7] = '{lu_rdy,                                        ex(1, 0, 0, 0, 2'd0)};
        tbl[8] = '{req_rdy,                                       ex(0, 0, 0, 0, 2'd0)};

        do_reset("init");
        for (int k = 0; k < 9; k++)
            step($sformatf("vec%0d", k), tbl[k].i, tbl[k].e);

        // Memory wait of three frozen cycles; hazards masked while frozen, honoured on release.
        do_reset("mw");
        step("mw_enter", req_wait, ex(0, 0, 1, 0, 2'd0));
        step("mw_w1",    mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 1, 0), ex(0, 0, 1, 0, 2'd1));
        step("mw_w2",    req_wait, ex(0, 0, 1, 0, 2'd1));
        step("mw_rel",   lu_rdy,   ex(1, 0, 0, 0, 2'd1));
        step("mw_run",   idle,     ex(0, 0, 0, 0, 2'd0));
        check("mw_total", 32'(MW_CNT), 32'd3);

        // Timeout: RUN freeze, four MEM_WAIT cycles, then ERROR holds regardless of READY.
        do_reset("to");
        step("to_enter", req_wait, ex(0, 0, 1, 0, 2'd0));
        for (int k = 1; k <= 4; k++)
            step($sformatf("to_w%0d", k), req_wait, ex(0, 0, 1, 0, 2'd1));
        step("to_err0", req_wait, ex(0, 0, 1, 1, 2'd2));
        step("to_err1", req_rdy,  ex(0, 0, 1, 1, 2'd2));
        step("to_err2", lu1,      ex(0, 0, 1, 1, 2'd2));
        check("to_mw_total", 32'(MW_CNT), 32'd5);
        do_reset("to_clr");
        step("to_after", idle, ex(0, 0, 0, 0, 2'd0));

        // Saturation of the load-use counter.
        do_reset("sat");
        for (int k = 0; k < 20; k++)
            step($sformatf("sat%0d", k), lu1, ex(1, 0, 0, 0, 2'd0));
        check("sat_final", 32'(LU_CNT), 32'd15);

        // Reset mid-wait returns to RUN in one edge.
        do_reset("mid");
        step("mid_enter", req_wait, ex(0, 0, 1, 0, 2'd0));
        step("mid_w1",    req_wait, ex(0, 0, 1, 0, 2'd1));
        do_reset("mid_rst");
        step("mid_after", req_rdy, ex(0, 0, 0, 0, 2'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
